// File: rtl/ysyx_23060208_mem_arbiter.sv
// ysyx_23060208_mem_arbiter: shares one SRAM port between the IFU and the LSU.
// Define YSYX_23060208_ARB_RR_EN for round-robin arbitration; by default the
// LSU has fixed priority and a STARVE_LIMIT counter eventually forces the IFU.
module ysyx_23060208_mem_arbiter #(
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifu_req_valid,
   output logic                  ifu_req_ready,
   input  logic [DATA_WIDTH-1:0] ifu_addr,
   output logic                  ifu_resp_valid,
   output logic [DATA_WIDTH-1:0] ifu_rdata,
   input  logic                  lsu_req_valid,
   output logic                  lsu_req_ready,
   input  logic [DATA_WIDTH-1:0] lsu_addr,
   input  logic                  lsu_wen,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   input  logic [3:0]            lsu_wmask,
   output logic                  lsu_resp_valid,
   output logic [DATA_WIDTH-1:0] lsu_rdata,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic [DATA_WIDTH-1:0] mem_addr,
   output logic                  mem_wen,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wmask,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
   state_e                  state_q;
   logic                    owner_q;
   logic [DATA_WIDTH-1:0]   addr_q;
   logic                    wen_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [3:0]              wmask_q;
   logic                    idle;
   logic                    grant_lsu;
   logic                    hs;
   logic                    resp;

   // Readies are held low while reset is asserted so nothing is accepted
   assign idle          = rst & (state_q == IDLE);
   assign hs            = idle & (ifu_req_valid | lsu_req_valid);
   assign lsu_req_ready = idle & grant_lsu;
   assign ifu_req_ready = idle & ifu_req_valid & ~grant_lsu;

`ifdef YSYX_23060208_ARB_RR_EN
   logic last_q;
   assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~last_q);
   // Remember who was granted last so a conflict goes to the other master
   always_ff @(posedge clk or negedge rst)
      if (!rst) last_q <= 1'b1;
      else if (hs) last_q <= grant_lsu;
`else
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
   logic [CW-1:0] starve_q;
   logic [CW-1:0] starve_d;
   assign grant_lsu = lsu_req_valid & (~ifu_req_valid | (starve_q != LIMIT));
   assign starve_d  = (grant_lsu & ifu_req_valid) ? ((starve_q == LIMIT) ? LIMIT : starve_q + 1'b1) : '0;
   // Count LSU grants that overtook a waiting IFU, saturating at the limit
   always_ff @(posedge clk or negedge rst)
      if (!rst) starve_q <= '0;
      else if (hs) starve_q <= starve_d;
`endif

   // Request/response sequencer with the buffered request payload
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         addr_q  <= '0;
         wen_q   <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (hs) begin
               state_q <= REQ;
               owner_q <= grant_lsu;
               addr_q  <= grant_lsu ? lsu_addr : ifu_addr;
               wen_q   <= grant_lsu & lsu_wen;
               wdata_q <= grant_lsu ? lsu_wdata : '0;
               wmask_q <= grant_lsu ? lsu_wmask : '0;
            end
            REQ:  if (mem_req_ready) state_q <= WAIT;
            WAIT: if (mem_resp_valid) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end

   assign resp           = (state_q == WAIT) & mem_resp_valid;
   assign ifu_resp_valid = resp & ~owner_q;
   assign lsu_resp_valid = resp & owner_q;
   assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
   assign lsu_rdata      = (lsu_resp_valid & ~wen_q) ? mem_rdata : '0;
   assign mem_req_valid  = (state_q == REQ);
   assign mem_addr       = addr_q;
   assign mem_wen        = wen_q;
   assign mem_wdata      = wdata_q;
   assign mem_wmask      = wmask_q;
   assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_ysyx_23060208_mem_arbiter.sv
// tb_ysyx_23060208_mem_arbiter: vector table, corner sequences and a random transaction model.
module tb_ysyx_23060208_mem_arbiter;
   localparam int LIM = 4;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask, mem_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   ysyx_23060208_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
   );

   typedef struct packed {
      logic iv; logic [31:0] ia; logic lv; logic [31:0] la; logic lw; logic [31:0] lwd;
      logic [3:0] lwm; logic mr; logic mresp; logic [31:0] mrd;
   } in_t;
   typedef struct packed {
      logic irdy; logic lrdy; logic mv; logic [31:0] ma; logic mw; logic [31:0] mwd;
      logic [3:0] mwm; logic irv; logic [31:0] ird; logic lrv; logic [31:0] lrd; logic busy;
   } out_t;
   typedef struct packed { in_t i; out_t o; } vec_t;
   vec_t vecs [18];

   function automatic out_t get_out();
      return '{ifu_req_ready, lsu_req_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata,
               mem_wmask, ifu_resp_valid, ifu_rdata, lsu_resp_valid, lsu_rdata, busy};
   endfunction

   // Payloads are only meaningful while their valid is high
   function automatic out_t norm(input out_t o);
      out_t r = o;
      if (!r.mv) begin r.ma = '0; r.mw = 1'b0; r.mwd = '0; r.mwm = '0; end
      if (!r.irv) r.ird = '0;
      if (!r.lrv) r.lrd = '0;
      return r;
   endfunction

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t v);
      ifu_req_valid = v.iv; ifu_addr = v.ia; lsu_req_valid = v.lv; lsu_addr = v.la;
      lsu_wen = v.lw; lsu_wdata = v.lwd; lsu_wmask = v.lwm;
      mem_req_ready = v.mr; mem_resp_valid = v.mresp; mem_rdata = v.mrd;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      drive('0);
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
   endtask

   initial begin
      out_t e;
      int g;
      bit ok;
      int starve;
      bit last_lsu, ip, lp, g_lsu, ew;
      logic [31:0] ia, la, lwd, ea, ed, rd;
      logic lw;
      logic [3:0] lwm, em;
      int stall, dly;

      //         iv  ia              lv  la              lw  lwd              lwm    mr  mresp mrd                irdy lrdy mv ma          mw mwd             mwm   irv ird           lrv lrd            busy
      vecs[0]  = '{'{1, 32'h80000000, 0, 32'h0,         0, 32'h0,          4'h0, 1, 0, 32'h0},        '{1, 0, 0, 32'h0,        0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        0}};
      vecs[1]  = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 1, 0, 32'h0},        '{0, 0, 1, 32'h80000000, 0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        1}};
      vecs[2]  = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 1, 1, 32'h413},      '{0, 0, 0, 32'h0,        0, 32'h0,        4'h0, 1, 32'h413, 0, 32'h0,        1}};
      vecs[3]  = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 0, 0, 32'h0},        '{0, 0, 0, 32'h0,        0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        0}};
      vecs[4]  = '{'{1, 32'h80000004, 1, 32'h80001000,  0, 32'h0,          4'h0, 1, 0, 32'h0},        '{0, 1, 0, 32'h0,        0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        0}};
      vecs[5]  = '{'{1, 32'h80000004, 0, 32'h0,         0, 32'h0,          4'h0, 1, 0, 32'h0},        '{0, 0, 1, 32'h80001000, 0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        1}};
      vecs[6]  = '{'{1, 32'h80000004, 0, 32'h0,         0, 32'h0,          4'h0, 1, 1, 32'h12345678}, '{0, 0, 0, 32'h0,        0, 32'h0,        4'h0, 0, 32'h0,   1, 32'h12345678, 1}};
      vecs[7]  = '{'{1, 32'h80000004, 0, 32'h0,         0, 32'h0,          4'h0, 1, 0, 32'h0},        '{1, 0, 0, 32'h0,        0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        0}};
      vecs[8]  = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 1, 0, 32'h0},        '{0, 0, 1, 32'h80000004, 0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        1}};
      vecs[9]  = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 1, 1, 32'h93},       '{0, 0, 0, 32'h0,        0, 32'h0,        4'h0, 1, 32'h93,  0, 32'h0,        1}};
      vecs[10] = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 0, 0, 32'h0},        '{0, 0, 0, 32'h0,        0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        0}};
      vecs[11] = '{'{0, 32'h0,        1, 32'h80002000,  1, 32'hDEADBEEF,   4'hF, 0, 0, 32'h0},        '{0, 1, 0, 32'h0,        0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        0}};
      vecs[12] = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 0, 0, 32'h0},        '{0, 0, 1, 32'h80002000, 1, 32'hDEADBEEF, 4'hF, 0, 32'h0,   0, 32'h0,        1}};
      vecs[13] = vecs[12];
      vecs[14] = vecs[12];
      vecs[15] = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 1, 0, 32'h0},        '{0, 0, 1, 32'h80002000, 1, 32'hDEADBEEF, 4'hF, 0, 32'h0,   0, 32'h0,        1}};
      vecs[16] = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 0, 1, 32'hCAFEF00D}, '{0, 0, 0, 32'h0,        0, 32'h0,        4'h0, 0, 32'h0,   1, 32'h0,        1}};
      vecs[17] = '{'{0, 32'h0,        0, 32'h0,         0, 32'h0,          4'h0, 1, 1, 32'hCAFEF00D}, '{0, 0, 0, 32'h0,        0, 32'h0,        4'h0, 0, 32'h0,   0, 32'h0,        0}};

      drive('0);
      #2;
      chk("reset outputs", get_out(), '0);
      do_reset();

      for (int i = 0; i < 18; i++) begin
         drive(vecs[i].i);
         @(negedge clk);
         chk($sformatf("vec[%0d]", i), norm(get_out()), vecs[i].o);
         tick();
      end

      // Both masters always valid: grant pattern after reset
      do_reset();
      drive('{1, 32'h80000010, 1, 32'h80003000, 0, 32'h0, 4'h0, 1, 1, 32'h55});
      g = 0;
      for (int c = 0; c < 100 && g < 10; c++) begin
         @(negedge clk);
         if (ifu_req_ready || lsu_req_ready) begin
`ifdef YSYX_23060208_ARB_RR_EN
            ok = (g % 2) == 1;
`else
            ok = (g % 5) != 4;
`endif
            chk($sformatf("starve grant %0d", g), {ifu_req_ready, lsu_req_ready}, {!ok, ok});
            g++;
         end
         tick();
      end
      if (g < 10) begin
         checks++; errors++;
         $display("FAIL starve grants: got %0d grants expected 10", g);
      end

      // Reset in WAIT abandons the transaction and ignores its late response
      drive('{0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 1, 1, 32'h0});
      ok = 0;
      for (int c = 0; c < 10 && !ok; c++) begin
         @(negedge clk);
         ok = !busy;
         tick();
      end
      chk("drain to idle", ok, 1'b1);
      drive('{1, 32'h80000008, 0, 32'h0, 0, 32'h0, 4'h0, 1, 0, 32'h0});
      tick();
      ifu_req_valid = 1'b1;
      tick();
      #2 rst = 1'b0;
      #1 chk("reset in WAIT", get_out(), '0);
      @(posedge clk); #1;
      rst = 1'b1;
      drive('{0, 32'h0, 0, 32'h0, 0, 32'h0, 4'h0, 0, 1, 32'hBAD});
      @(negedge clk);
      chk("late resp ignored", get_out(), '0);
      tick();
      drive('{1, 32'h8000000C, 0, 32'h0, 0, 32'h0, 4'h0, 1, 0, 32'h0});
      @(negedge clk);
      chk("post-reset ifu ready", ifu_req_ready, 1'b1);
      tick();
      ifu_req_valid = 1'b0;
      @(negedge clk);
      chk("post-reset mem req", {mem_req_valid, mem_addr}, {1'b1, 32'h8000000C});
      tick();
      mem_resp_valid = 1'b1; mem_rdata = 32'h00100073;
      @(negedge clk);
      chk("post-reset ifu resp", {ifu_resp_valid, ifu_rdata, lsu_resp_valid}, {1'b1, 32'h00100073, 1'b0});
      tick();
      mem_resp_valid = 1'b0;
      @(negedge clk);
      chk("post-reset idle", busy, 1'b0);

      // Random transactions against a grant/response model
      do_reset();
      starve = 0; last_lsu = 1; ip = 0; lp = 0;
      ia = '0; la = '0; lwd = '0; lw = 0; lwm = '0;
      for (int t = 0; t < 250; t++) begin
         if (!ip && $urandom_range(1, 0) == 1) begin ip = 1; ia = $urandom; end
         if (!lp && ($urandom_range(1, 0) == 1 || !ip)) begin
            lp = 1; la = $urandom; lw = 1'($urandom); lwd = $urandom; lwm = 4'($urandom);
         end
         drive('{ip, ia, lp, la, lw, lwd, lwm, 1'($urandom), 1'($urandom), $urandom});
`ifdef YSYX_23060208_ARB_RR_EN
         g_lsu = lp && (!ip || !last_lsu);
`else
         g_lsu = lp && (!ip || starve < LIM);
`endif
         @(negedge clk);
         e = '0; e.irdy = !g_lsu; e.lrdy = g_lsu;
         chk($sformatf("rnd %0d grant", t), norm(get_out()), e);
         if (g_lsu) starve = ip ? ((starve < LIM) ? starve + 1 : LIM) : 0;
         else starve = 0;
         last_lsu = g_lsu;
         ea = g_lsu ? la : ia; ew = g_lsu && lw; ed = g_lsu ? lwd : 32'h0; em = g_lsu ? lwm : 4'h0;
         if (g_lsu) lp = 0; else ip = 0;
         tick();
         ifu_req_valid = ip; lsu_req_valid = lp;
         stall = $urandom_range(3, 0);
         for (int k = 0; k <= stall; k++) begin
            mem_req_ready = (k == stall); mem_resp_valid = 1'($urandom); mem_rdata = $urandom;
            @(negedge clk);
            e = '0; e.mv = 1; e.ma = ea; e.mw = ew; e.mwd = ed; e.mwm = em; e.busy = 1;
            chk($sformatf("rnd %0d req %0d", t, k), norm(get_out()), e);
            tick();
         end
         dly = $urandom_range(3, 0);
         for (int k = 0; k <= dly; k++) begin
            rd = $urandom;
            mem_resp_valid = (k == dly); mem_req_ready = 1'($urandom); mem_rdata = rd;
            @(negedge clk);
            e = '0; e.busy = 1;
            if (k == dly) begin
               e.irv = !g_lsu; e.ird = g_lsu ? 32'h0 : rd;
               e.lrv = g_lsu;  e.lrd = (g_lsu && !ew) ? rd : 32'h0;
            end
            chk($sformatf("rnd %0d resp %0d", t, k), norm(get_out()), e);
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ysyx_23060208_mem_arbiter.md
Name: ysyx_23060208_mem_arbiter

Overview:
- Two-master, one-slave arbiter that shares the single data/instruction SRAM port between the IFU (instruction fetch) and the EXU load/store path (LSU side).
- Accepts one request at a time, buffers it, and drives it to the SRAM with a valid/ready handshake. It then waits for the SRAM response and routes it back to the owning master.
- Sits between the IFU/EXU and the memory model; it is the sole sequencer of SRAM traffic.

Parameters:
- DATA_WIDTH, 32, address/data width
- STARVE_LIMIT, 4, consecutive LSU grants allowed while IFU waits before IFU is forced (fixed-priority mode only)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  DATA_WIDTH  fetch address
- ifu_resp_valid  out  1  fetch data valid (1-cycle pulse)
- ifu_rdata  out  DATA_WIDTH  fetch data
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_addr  in  DATA_WIDTH  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DATA_WIDTH  store data
- lsu_wmask  in  4  store byte mask
- lsu_resp_valid  out  1  load data / store ack (1-cycle pulse)
- lsu_rdata  out  DATA_WIDTH  load data (0 for stores)
- mem_req_valid  out  1  request to SRAM
- mem_req_ready  in  1  SRAM accepts request
- mem_addr  out  DATA_WIDTH  SRAM address
- mem_wen  out  1  SRAM write enable
- mem_wdata  out  DATA_WIDTH  SRAM write data
- mem_wmask  out  4  SRAM byte mask
- mem_resp_valid  in  1  SRAM response
- mem_rdata  in  DATA_WIDTH  SRAM read data
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, REQ, WAIT. Registers: owner (0 = IFU, 1 = LSU), request buffer (addr/wen/wdata/wmask), starve_cnt.
- IDLE:
  - Grant selection when both masters are valid: LSU wins, unless starve_cnt == STARVE_LIMIT, in which case IFU wins.
  - Single valid master is granted.
  - {ifu,lsu}_req_ready = 1 combinationally, only for the granted master, only in IDLE.
  - On the handshake: latch the request into the buffer, set owner, go to REQ.
  - IFU requests are buffered with wen = 0, wmask = 0, wdata = 0.
- REQ:
  - mem_req_valid = 1 and mem_* are driven from the buffer, held stable until mem_req_ready.
  - On mem_req_ready, go to WAIT.
- WAIT:
  - On mem_resp_valid, pulse resp_valid of the owner for that same cycle, then return to IDLE.
  - rdata = mem_rdata for loads/fetches; lsu_rdata = 0 for stores.
  - The non-owner resp_valid stays 0.
- mem_resp_valid outside WAIT is ignored. mem_req_ready outside REQ is ignored.
- Latency: handshake at cycle N, mem_req_valid at N+1, earliest resp pulse at N+2 (SRAM ready and response both at N+1 → response at N+2). The next request can be accepted the cycle after the resp pulse.
- starve_cnt (saturating at STARVE_LIMIT):
  - Increments when LSU is granted while ifu_req_valid = 1.
  - Clears on any IFU grant, or when an LSU grant occurs with ifu_req_valid = 0.
- Masters must hold valid and payload until ready. The arbiter never drops an accepted request.
- Reset (async assert, any state, including mid-transaction):
  - State = IDLE; owner = 0; buffer = 0; starve_cnt = 0.
  - All *_valid, *_ready, mem_* outputs = 0; busy = 0.
  - An in-flight transaction is abandoned and its late mem_resp_valid is ignored (not in WAIT).

Optional Feature:
- Macro: YSYX_23060208_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Conflict in IDLE: grant the master that was not granted last; last-grant register resets to LSU, so IFU wins the first conflict.
  - starve_cnt is not instantiated.
- Undefined: fixed LSU priority with the STARVE_LIMIT anti-starvation counter as above.

Test Plan:
- IFU only, addr 0x8000_0000, mem_req_ready = 1, mem_resp 1 cycle later with rdata 0x0000_0413 → ifu_req_ready at N, mem_req_valid at N+1, ifu_resp_valid = 1 with ifu_rdata = 0x0000_0413 at N+2, busy 0 at N+3.
- Simultaneous IFU 0x8000_0004 and LSU load 0x8000_1000 (fixed priority) → LSU granted first, mem_addr = 0x8000_1000, wen = 0. IFU is granted after the LSU resp pulse.
- LSU store addr 0x8000_2000, wdata 0xDEAD_BEEF, wmask 4'b1111, mem_req_ready held 0 for 3 cycles → mem_* stable 3 cycles; lsu_resp_valid pulse with lsu_rdata = 0; ifu_resp_valid stays 0.
- LSU valid continuously, IFU valid continuously, STARVE_LIMIT = 4 → exactly 4 LSU grants, then 1 IFU grant, then the counter restarts. (With RR macro: strict alternation starting with IFU.)
- Assert rst = 0 in WAIT; release; then inject mem_resp_valid = 1 → no resp pulse, state IDLE, all outputs 0. A new IFU request then completes normally.
